// File: rtl/ltl_report_collector_c3.sv
// Collects cluster-3 stage-0 LTL report lines into timestamped records and buffers
// them in a first-word-fall-through FIFO drained over a valid/ready interface.
module ltl_report_collector_c3 #(
    parameter int unsigned NUM_REPORTS = 40,
    parameter int unsigned TS_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DROP_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [NUM_REPORTS-1:0]        report_in,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [TS_WIDTH-1:0]           rec_ts,
    output logic [NUM_REPORTS-1:0]        rec_reports,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [DROP_WIDTH-1:0]         drop_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned REC_W  = TS_WIDTH + NUM_REPORTS;

    logic [REC_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [TS_WIDTH-1:0] ts;
    logic [REC_W-1:0]    head_c;
    logic                push_req_c;
    logic                pop_c;
    logic                full_c;
    logic                push_c;
    logic                drop_c;

    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign rec_valid  = (fill_level != '0);
    assign full_c     = (fill_level == FILL_W'(FIFO_DEPTH));
    assign pop_c      = rec_valid & rec_ready;
    assign push_req_c = run & (|report_in);
    assign push_c     = push_req_c & (~full_c | pop_c);
    assign drop_c     = push_req_c & full_c & ~pop_c;

    // Head is gated so an empty FIFO presents zeros rather than stale storage.
    assign head_c      = mem[rd_ptr];
    assign rec_ts      = rec_valid ? head_c[REC_W-1:NUM_REPORTS] : '0;
    assign rec_reports = rec_valid ? head_c[NUM_REPORTS-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else if (run) begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            mem[wr_ptr] <= {ts, report_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                fill_level <= fill_level + FILL_W'(1);
            end else if (pop_c && !push_c) begin
                fill_level <= fill_level - FILL_W'(1);
            end
        end
    end

    // A drop coinciding with a clear leaves exactly that one drop recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= DROP_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + DROP_WIDTH'(1);
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_ltl_report_collector_c3.sv
// Scoreboard bench for ltl_report_collector_c3: directed stimulus with hand-computed
// expected records, checked by an independent handshake monitor.
module tb_ltl_report_collector_c3;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [39:0] report_in;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_ts;
    logic [39:0] rec_reports;
    logic [3:0]  fill_level;
    logic [15:0] drop_count;
    logic        overflow;
    logic        clear_overflow;

    int checks   = 0;
    int failures = 0;
    logic [71:0] exp_q[$];

    ltl_report_collector_c3 dut (
        .clk(clk), .reset(reset), .run(run), .report_in(report_in),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts),
        .rec_reports(rec_reports), .fill_level(fill_level), .drop_count(drop_count),
        .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input logic [31:0] ts, input logic [39:0] rep);
        exp_q.push_back({ts, rep});
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; report_in = '0; rec_ready = 1'b0; clear_overflow = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Monitor: a transfer happens at the next edge whenever valid and ready are both high.
    logic [71:0] exp_rec;
    always @(negedge clk) begin
        if (!reset && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record: got ts=%0d rep=%0h expected none", rec_ts, rec_reports);
            end else begin
                exp_rec = exp_q.pop_front();
                check("rec_ts", 64'(rec_ts), 64'(exp_rec[71:40]));
                check("rec_reports", 64'(rec_reports), 64'(exp_rec[39:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single record from a sparse report stream
        do_reset();
        check("rst_valid", 64'(rec_valid), 64'd0);
        check("rst_fill", 64'(fill_level), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_ts", 64'(rec_ts), 64'd0);
        check("rst_rep", 64'(rec_reports), 64'd0);
        run = 1'b1; rec_ready = 1'b1;
        expect_rec(32'd2, 40'h1);
        for (int c = 0; c < 5; c++) begin
            report_in = (c == 2) ? 40'h1 : 40'h0;
            step();
            if (c == 2) check("t1_valid_on", 64'(rec_valid), 64'd1);
            if (c == 3) check("t1_valid_off", 64'(rec_valid), 64'd0);
        end
        check("t1_fill", 64'(fill_level), 64'd0);

        // 2: overflow with ready low, then drain in order
        do_reset();
        run = 1'b1; report_in = 40'h80_0000_0001;
        for (int c = 0; c < 8; c++) expect_rec(32'(c), 40'h80_0000_0001);
        for (int c = 0; c < 10; c++) step();
        check("t2_fill", 64'(fill_level), 64'd8);
        check("t2_drop", 64'(drop_count), 64'd2);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_head_hold", 64'(rec_ts), 64'd0);
        run = 1'b0; rec_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        check("t2_empty", 64'(rec_valid), 64'd0);
        check("t2_fill0", 64'(fill_level), 64'd0);

        // 3: full FIFO with simultaneous push and pop (ts continues from 10)
        rec_ready = 1'b0; run = 1'b1; report_in = 40'hA;
        for (int c = 0; c < 8; c++) expect_rec(32'(10 + c), 40'hA);
        for (int c = 0; c < 8; c++) step();
        check("t3_full", 64'(fill_level), 64'd8);
        rec_ready = 1'b1; report_in = 40'hB;
        expect_rec(32'd18, 40'hB);
        step();
        check("t3_fill", 64'(fill_level), 64'd8);
        check("t3_drop", 64'(drop_count), 64'd2);
        check("t3_head", 64'(rec_ts), 64'd11);
        run = 1'b0;
        for (int c = 0; c < 8; c++) step();
        check("t3_empty", 64'(rec_valid), 64'd0);

        // 4: run toggling, paused drain, ts held while paused
        do_reset();
        report_in = 40'hF;
        expect_rec(32'd0, 40'hF);
        expect_rec(32'd1, 40'hF);
        run = 1'b1; step();
        run = 1'b0; step();
        run = 1'b1; step();
        check("t4_fill", 64'(fill_level), 64'd2);
        run = 1'b0; rec_ready = 1'b1;
        step(); step();
        check("t4_fill0", 64'(fill_level), 64'd0);
        step();
        rec_ready = 1'b0; run = 1'b1; report_in = 40'h1;
        expect_rec(32'd2, 40'h1);
        step();
        check("t4_ts_held", 64'(rec_ts), 64'd2);
        run = 1'b0; rec_ready = 1'b1;
        step();

        // 5: clear_overflow alone and with a concurrent drop
        do_reset();
        run = 1'b1; report_in = 40'h1;
        for (int c = 0; c < 8; c++) expect_rec(32'(c), 40'h1);
        for (int c = 0; c < 11; c++) step();
        check("t5_drop3", 64'(drop_count), 64'd3);
        check("t5_ovf1", 64'(overflow), 64'd1);
        run = 1'b0; clear_overflow = 1'b1;
        step();
        check("t5_clr_drop", 64'(drop_count), 64'd0);
        check("t5_clr_ovf", 64'(overflow), 64'd0);
        run = 1'b1;
        step();
        check("t5_win_drop", 64'(drop_count), 64'd1);
        check("t5_win_ovf", 64'(overflow), 64'd1);
        check("t5_win_fill", 64'(fill_level), 64'd8);
        run = 1'b0; clear_overflow = 1'b0; rec_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        check("t5_empty", 64'(rec_valid), 64'd0);

        // 6: reset with records stored discards them without counting drops
        rec_ready = 1'b0; run = 1'b1; report_in = 40'h5;
        for (int c = 0; c < 5; c++) step();
        check("t6_fill5", 64'(fill_level), 64'd5);
        reset = 1'b1; rec_ready = 1'b1;
        step();
        reset = 1'b0; run = 1'b0;
        check("t6_valid", 64'(rec_valid), 64'd0);
        check("t6_fill", 64'(fill_level), 64'd0);
        check("t6_drop", 64'(drop_count), 64'd0);
        check("t6_ovf", 64'(overflow), 64'd0);
        run = 1'b1; report_in = 40'h3;
        expect_rec(32'd0, 40'h3);
        step();
        run = 1'b0;
        step();
        check("t6_fill0", 64'(fill_level), 64'd0);

        step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ltl_report_collector_c3.md
Name: ltl_report_collector_c3

Overview:
- Downstream consumer of cluster-3 stage-0 automata report lines: 10 LTL monitors × 4 reports = 40 bits.
- Each run cycle with at least one active report bit becomes one record: {timestamp, 40-bit report vector}.
- Records are buffered in a small first-word-fall-through (FWFT) FIFO and drained over a valid/ready interface toward the monitor readout/core side.
- Drops on overflow are counted, not silently lost.

Parameters:
NUM_REPORTS, 40, width of the report vector (ltl0c3..ltl9c3 × out_4/6/9/11, packed ltlNc3 at bits [4N+3:4N] in order out_4, out_6, out_9, out_11).
TS_WIDTH, 32, timestamp counter width.
FIFO_DEPTH, 8, record slots; power of two, ≥2.
DROP_WIDTH, 16, width of the dropped-record counter.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
run  input  1  capture/timestamp enable, same meaning as the stage's run.
report_in  input  NUM_REPORTS  report bits from the stage, sampled each clk.
rec_valid  output  1  FIFO head record available.
rec_ready  input  1  consumer accepts head record.
rec_ts  output  TS_WIDTH  timestamp of head record.
rec_reports  output  NUM_REPORTS  report vector of head record.
fill_level  output  log2(FIFO_DEPTH)+1  records currently stored.
drop_count  output  DROP_WIDTH  records dropped since reset; saturating.
overflow  output  1  sticky: at least one drop since reset or clear.
clear_overflow  input  1  clears overflow and drop_count.

Behaviour:
- Reset: one clk edge with reset=1 sets the following state:
  - FIFO empty, rec_valid=0, fill_level=0.
  - ts counter=0, drop_count=0, overflow=0.
  - rec_ts and rec_reports read 0.
- Reset overrides all other inputs. Reset mid-operation discards stored records and does not count them as drops.
- Timestamp counter:
  - +1 on every edge with run=1 and reset=0; holds when run=0.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Push condition: edge with run=1 AND |report_in. The record written is {current ts before increment, report_in}. The first run cycle after reset yields ts=0.
- report_in is ignored when run=0. An all-zero vector is never pushed.
- Pop condition: edge with rec_valid=1 AND rec_ready=1. Pop is independent of run, so draining while paused is allowed. rec_ready while empty has no effect.
- Latency: a push at edge N on an empty FIFO gives rec_valid=1 with that record from just after edge N.
- Handshake:
  - rec_ts and rec_reports stay stable while rec_valid=1 and rec_ready=0.
  - Next record is presented in the cycle after a pop.
- Full FIFO (fill_level=FIFO_DEPTH):
  - A push with a simultaneous pop is accepted; fill_level is unchanged.
  - A push without a pop is dropped: drop_count +1 (saturating at all-ones), overflow set to 1.
- Empty FIFO with simultaneous push and pop: the pop is ignored because rec_valid=0 at that edge; the push is stored.
- fill_level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by fill_level or an extra pointer bit.
- clear_overflow:
  - Zeroes drop_count and overflow at the edge.
  - If a drop occurs at the same edge, the drop wins: drop_count=1, overflow=1.
  - Does not affect FIFO contents or ts.
- Storage and implementation:
  - Ordering is strictly FIFO; no coalescing of records.
  - All outputs are registered or derived from registered state; no combinational path from report_in to rec_*.

Test Plan:
1. Reset, then run=1 for 5 cycles with report_in=0 except bit 0 set in cycle 3, rec_ready=1 → exactly one record: rec_ts=2, rec_reports=40'h1, rec_valid high for one cycle, fill_level returns to 0.
2. rec_ready=0, run=1, report_in=40'h80_0000_0001 for 10 consecutive cycles from ts=0 → fill_level=8; ts 0..7 stored; drop_count=2, overflow=1. Then drain → 8 records in order ts 0..7, then rec_valid=0.
3. FIFO full, push and pop at the same edge → head advances, new record stored at tail, fill_level stays 8, drop_count unchanged.
4. run toggled 1,0,1 with report_in=40'hF on every cycle → 2 records with ts 0 and 1. Draining with run=0 works, and ts holds during run=0.
5. overflow=1 and drop_count=3, then pulse clear_overflow with no concurrent drop → 0/0. Repeat with a concurrent drop → drop_count=1, overflow=1.
6. Reset asserted with 5 records stored and rec_ready=1 → next cycle rec_valid=0, fill_level=0, drop_count=0, ts restarts at 0 for the first post-reset push.
